// File: rtl/bp_cce_dir_wg_reader_if.sv
// Handshake and data bundle between a CCE way-group directory reader and its client.
// The slave modport is the reader; the master modport is the requester plus directory RAM.
interface bp_cce_dir_wg_reader_if #(
    parameter int tag_width_p       = 28,
    parameter int wg_width_p        = 6,
    parameter int dir_addr_width_p  = 10,
    parameter int row_width_p       = 124,
    parameter int num_lce_p         = 4,
    parameter int lce_assoc_width_p = 3
);
    logic                                   start_v_i;
    logic                                   start_ready_o;
    logic [tag_width_p-1:0]                 tag_i;
    logic [wg_width_p-1:0]                  wg_i;
    logic                                   rd_v_o;
    logic [dir_addr_width_p-1:0]            rd_addr_o;
    logic                                   rd_data_v_i;
    logic [row_width_p-1:0]                 rd_data_i;
    logic                                   sharers_v_o;
    logic [num_lce_p-1:0]                   sharers_hits_o;
    logic [num_lce_p*lce_assoc_width_p-1:0] sharers_ways_o;
    logic [num_lce_p*3-1:0]                 sharers_coh_states_o;
    logic                                   multi_hit_o;

    modport slave (
        input  start_v_i, tag_i, wg_i, rd_data_v_i, rd_data_i,
        output start_ready_o, rd_v_o, rd_addr_o, sharers_v_o, sharers_hits_o,
               sharers_ways_o, sharers_coh_states_o, multi_hit_o
    );

    modport master (
        output start_v_i, tag_i, wg_i, rd_data_v_i, rd_data_i,
        input  start_ready_o, rd_v_o, rd_addr_o, sharers_v_o, sharers_hits_o,
               sharers_ways_o, sharers_coh_states_o, multi_hit_o
    );
endinterface

// File: rtl/bp_cce_dir_wg_reader.sv
// Reads every directory row of one way-group and builds per-LCE sharer hit/way/state vectors
// for a target tag. Rows are issued back-to-back; each response is folded in as it arrives.
package bp_cce_dir_wg_reader_pkg;
    typedef enum logic [2:0] {
        e_COH_I = 3'b000,
        e_COH_S = 3'b001,
        e_COH_E = 3'b010,
        e_COH_F = 3'b011,
        e_COH_M = 3'b110,
        e_COH_O = 3'b111
    } bp_coh_states_e;

    typedef enum {e_bp_default_cfg, e_bp_half_cfg} bp_params_e;

    typedef struct packed {
        int num_lce;
        int lce_assoc;
        int lce_assoc_width;
        int lce_id_width;
    } bp_proc_param_s;

    function automatic bp_proc_param_s bp_proc_param_f(bp_params_e cfg);
        bp_proc_param_s p;
        case (cfg)
            e_bp_half_cfg: p = '{num_lce: 2, lce_assoc: 4, lce_assoc_width: 2, lce_id_width: 1};
            default:       p = '{num_lce: 4, lce_assoc: 8, lce_assoc_width: 3, lce_id_width: 2};
        endcase
        return p;
    endfunction
endpackage

module bp_cce_dir_wg_reader
    import bp_cce_dir_wg_reader_pkg::*;
#(
    parameter bp_params_e bp_params_p  = e_bp_default_cfg,
    parameter int tag_width_p          = 28,
    parameter int entries_per_row_p    = 4,
    parameter int wg_width_p           = 6,
    parameter int dir_addr_width_p     = 10
) (
    input logic                  clk_i,
    input logic                  reset_i,
    bp_cce_dir_wg_reader_if.slave io
);
    localparam bp_proc_param_s proc_lp = bp_proc_param_f(bp_params_p);
    localparam int num_lce_p         = proc_lp.num_lce;
    localparam int lce_assoc_p       = proc_lp.lce_assoc;
    localparam int lce_assoc_width_p = proc_lp.lce_assoc_width;
    localparam int rows_per_lce      = lce_assoc_p / entries_per_row_p;
    localparam int rows_per_wg       = num_lce_p * rows_per_lce;
    localparam int entry_width       = tag_width_p + 3;
    localparam int cnt_w             = $clog2(rows_per_wg + 1);

    typedef enum logic [1:0] {e_idle, e_read, e_done} state_e;

    state_e                                       state_r, state_n;
    logic [cnt_w-1:0]                             issue_cnt_r, resp_cnt_r;
    logic [tag_width_p-1:0]                       tag_r;
    logic [wg_width_p-1:0]                        wg_r;
    logic [num_lce_p-1:0]                         hits_r, hits_n;
    logic [num_lce_p-1:0][lce_assoc_width_p-1:0]  ways_r, ways_n;
    logic [num_lce_p-1:0][2:0]                    states_r, states_n;
    logic                                         multi_r, multi_n;
    logic [entries_per_row_p-1:0][entry_width-1:0] row_entries;
    logic                                         accept, resp_take, last_resp;
    int                                           row_lce, way_base;

    assign row_entries = io.rd_data_i;
    assign accept      = io.start_v_i & io.start_ready_o;
    assign resp_take   = (state_r == e_read) & io.rd_data_v_i & (resp_cnt_r < cnt_w'(rows_per_wg));
    assign last_resp   = resp_take & (resp_cnt_r == cnt_w'(rows_per_wg - 1));

    assign io.start_ready_o        = (state_r != e_read);
    assign io.rd_v_o               = (state_r == e_read) & (issue_cnt_r < cnt_w'(rows_per_wg));
    assign io.rd_addr_o            = dir_addr_width_p'(int'(wg_r) * rows_per_wg + int'(issue_cnt_r));
    assign io.sharers_v_o          = (state_r == e_done);
    assign io.sharers_hits_o       = hits_r;
    assign io.sharers_ways_o       = ways_r;
    assign io.sharers_coh_states_o = states_r;
    assign io.multi_hit_o          = multi_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= e_idle;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_idle, e_done: if (io.start_v_i) state_n = e_read;
            e_read:         if (last_resp)    state_n = e_done;
            default:        state_n = e_idle;
        endcase
    end

    // Rows arrive in ascending way order, so the first recorded hit per LCE is
    // always its lowest way; any later hit only flags the error.
    always_comb begin
        hits_n   = hits_r;
        ways_n   = ways_r;
        states_n = states_r;
        multi_n  = multi_r;
        row_lce  = int'(resp_cnt_r) / rows_per_lce;
        way_base = (int'(resp_cnt_r) % rows_per_lce) * entries_per_row_p;
        for (int k = 0; k < entries_per_row_p; k++) begin
            if ((row_entries[k][2:0] != e_COH_I) && (row_entries[k][entry_width-1:3] == tag_r)) begin
                for (int l = 0; l < num_lce_p; l++) begin
                    if (l == row_lce) begin
                        if (hits_n[l]) begin
                            multi_n = 1'b1;
                        end else begin
                            hits_n[l]   = 1'b1;
                            ways_n[l]   = lce_assoc_width_p'(way_base + k);
                            states_n[l] = row_entries[k][2:0];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || accept) begin
            issue_cnt_r <= '0;
            resp_cnt_r  <= '0;
            hits_r      <= '0;
            ways_r      <= '0;
            states_r    <= {num_lce_p{e_COH_I}};
            multi_r     <= 1'b0;
        end else begin
            if (io.rd_v_o) issue_cnt_r <= issue_cnt_r + 1'b1;
            if (resp_take) begin
                resp_cnt_r <= resp_cnt_r + 1'b1;
                hits_r     <= hits_n;
                ways_r     <= ways_n;
                states_r   <= states_n;
                multi_r    <= multi_n;
            end
        end
        if (reset_i) begin
            tag_r <= '0;
            wg_r  <= '0;
        end else if (accept) begin
            tag_r <= io.tag_i;
            wg_r  <= io.wg_i;
        end
    end
endmodule

// File: tb/tb_bp_cce_dir_wg_reader.sv
// Directed bench: a directory RAM model answers row reads; a scoreboard queue holds the
// hand-computed sharer vectors and a monitor compares them whenever sharers_v_o rises.
module tb_bp_cce_dir_wg_reader;
    localparam int TW = 28, EW = 31, EPR = 4, ROWW = 124, WGW = 6, DAW = 10, NL = 4, AW = 3;
    localparam logic [2:0] ST_I = 3'd0, ST_S = 3'd1, ST_E = 3'd2, ST_F = 3'd3, ST_M = 3'd6, ST_O = 3'd7;

    typedef struct packed {
        logic [NL-1:0]    hits;
        logic [NL*AW-1:0] ways;
        logic [NL*3-1:0]  st;
        logic             multi;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bp_cce_dir_wg_reader_if #(
        .tag_width_p(TW), .wg_width_p(WGW), .dir_addr_width_p(DAW),
        .row_width_p(ROWW), .num_lce_p(NL), .lce_assoc_width_p(AW)
    ) dut_if ();

    bp_cce_dir_wg_reader #(
        .tag_width_p(TW), .entries_per_row_p(EPR), .wg_width_p(WGW), .dir_addr_width_p(DAW)
    ) dut (
        .clk_i(clk), .reset_i(reset), .io(dut_if)
    );

    int   errs = 0;
    int   checks = 0;
    exp_t q[$];

    logic [ROWW-1:0] mem [1024];
    logic            last_v = 1'b0;
    logic [DAW-1:0]  last_addr = '0;
    logic            stray = 1'b0;
    logic [ROWW-1:0] stray_row = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] h, input logic [11:0] w, input logic [11:0] s, input logic m);
        exp_t e;
        e.hits = h; e.ways = w; e.st = s; e.multi = m;
        return e;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask

    task automatic set_entry(input int wg, input int lce, input int way, input logic [TW-1:0] tag, input logic [2:0] st);
        int row;
        row = wg * 8 + lce * 2 + way / 4;
        mem[row][(way % 4) * EW +: EW] = {tag, st};
    endtask

    // Directory RAM model: data returned the cycle after each read strobe.
    initial begin
        dut_if.rd_data_v_i = 1'b0;
        dut_if.rd_data_i   = '0;
        forever begin
            @(negedge clk);
            dut_if.rd_data_v_i = last_v | stray;
            dut_if.rd_data_i   = stray ? stray_row : mem[last_addr];
            last_v    = dut_if.rd_v_o;
            last_addr = dut_if.rd_addr_o;
        end
    end

    // Monitor: compare on each rising edge of sharers_v_o.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (dut_if.sharers_v_o && !prev) begin
                if (q.size() == 0) begin
                    chk("spurious_sharers_v", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    chk("hits",   dut_if.sharers_hits_o, e.hits);
                    chk("ways",   dut_if.sharers_ways_o, e.ways);
                    chk("states", dut_if.sharers_coh_states_o, e.st);
                    chk("multi",  dut_if.multi_hit_o, e.multi);
                end
            end
            prev = dut_if.sharers_v_o;
        end
    end

    // Called at a negedge with the reader able to accept; returns at the negedge of cycle 10.
    task automatic do_txn(input logic [TW-1:0] tag, input int wg, input exp_t e, input bit hold,
                          input logic [TW-1:0] mid_tag);
        chk("start_ready", dut_if.start_ready_o, 1);
        dut_if.start_v_i = 1'b1;
        dut_if.tag_i     = tag;
        dut_if.wg_i      = WGW'(wg);
        q.push_back(e);
        @(negedge clk);
        if (hold) begin
            dut_if.tag_i = mid_tag;
            dut_if.wg_i  = WGW'(wg + 1);
        end else begin
            dut_if.start_v_i = 1'b0;
        end
        chk("sharers_v_drop", dut_if.sharers_v_o, 0);
        for (int c = 1; c <= 8; c++) begin
            chk("rd_v", dut_if.rd_v_o, 1);
            chk("rd_addr", dut_if.rd_addr_o, (wg * 8 + c - 1) % 1024);
            chk("ready_in_read", dut_if.start_ready_o, 0);
            @(negedge clk);
        end
        chk("rd_v_end", dut_if.rd_v_o, 0);
        chk("sharers_v_early", dut_if.sharers_v_o, 0);
        @(negedge clk);
        chk("sharers_v", dut_if.sharers_v_o, 1);
        chk("ready_done", dut_if.start_ready_o, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"},  dut_if.start_ready_o, 1);
        chk({tag, "_rd_v"},   dut_if.rd_v_o, 0);
        chk({tag, "_shr_v"},  dut_if.sharers_v_o, 0);
        chk({tag, "_hits"},   dut_if.sharers_hits_o, 0);
        chk({tag, "_ways"},   dut_if.sharers_ways_o, 0);
        chk({tag, "_states"}, dut_if.sharers_coh_states_o, 0);
        chk({tag, "_multi"},  dut_if.multi_hit_o, 0);
    endtask

    initial begin
        dut_if.start_v_i = 1'b0;
        dut_if.tag_i     = '0;
        dut_if.wg_i      = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("reset");

        // All entries invalid
        do_txn(28'h5A, 3, mk(4'b0000, 12'h000, 12'h000, 1'b0), 1'b0, '0);

        // Two hits on different LCEs; a matching entry in another way-group is not read
        clear_mem();
        set_entry(3, 2, 5, 28'h5A, ST_M);
        set_entry(3, 0, 0, 28'h5A, ST_S);
        set_entry(4, 1, 0, 28'h5A, ST_M);
        do_txn(28'h5A, 3, mk(4'b0101, {3'd0, 3'd5, 3'd0, 3'd0}, {ST_I, ST_M, ST_I, ST_S}, 1'b0), 1'b0, '0);

        // Multi-hit on LCE1 keeps lowest way; top way of last LCE in way-group 0
        clear_mem();
        set_entry(0, 1, 2, 28'h5A, ST_S);
        set_entry(0, 1, 6, 28'h5A, ST_S);
        set_entry(0, 3, 7, 28'h5A, ST_O);
        do_txn(28'h5A, 0, mk(4'b1010, {3'd7, 3'd0, 3'd2, 3'd0}, {ST_O, ST_I, ST_S, ST_I}, 1'b1), 1'b0, '0);

        // Matching tag in state I and valid entry with wrong tag; last way-group
        clear_mem();
        set_entry(63, 0, 1, 28'h5A, ST_I);
        set_entry(63, 3, 4, 28'h5B, ST_E);
        do_txn(28'h5A, 63, mk(4'b0000, 12'h000, 12'h000, 1'b0), 1'b0, '0);

        // Stray response in DONE must not disturb held results
        stray_row = '0;
        stray_row[EW-1:0] = {28'h5A, ST_M};
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        @(negedge clk);
        chk("stray_hits", dut_if.sharers_hits_o, 0);
        chk("stray_shr_v", dut_if.sharers_v_o, 1);

        // Reset in cycle 4 of READ; the in-flight response lands the cycle after reset
        clear_mem();
        set_entry(5, 1, 5, 28'h5A, ST_M);
        dut_if.start_v_i = 1'b1;
        dut_if.tag_i     = 28'h5A;
        dut_if.wg_i      = WGW'(5);
        @(negedge clk);
        dut_if.start_v_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_v", dut_if.rd_v_o, 1);
        chk("rst_rd_addr", dut_if.rd_addr_o, 43);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("midrst");
        @(negedge clk);
        chk_idle("postrst");
        do_txn(28'h5A, 5, mk(4'b0010, {3'd0, 3'd0, 3'd5, 3'd0}, {ST_I, ST_I, ST_M, ST_I}, 1'b0), 1'b0, '0);

        // start held through READ, then re-accepted in DONE with a new tag
        clear_mem();
        set_entry(10, 0, 3, 28'h5A, ST_E);
        set_entry(10, 2, 0, 28'h5B, ST_F);
        do_txn(28'h5A, 10, mk(4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, {ST_I, ST_I, ST_I, ST_E}, 1'b0), 1'b1, 28'h5B);
        do_txn(28'h5B, 10, mk(4'b0100, {3'd0, 3'd0, 3'd0, 3'd0}, {ST_I, ST_F, ST_I, ST_I}, 1'b0), 1'b0, '0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
